// File: rtl/rv_ctrl_pkg.sv
// Shared control-bundle encodings for the RV32I(+M) decode stage.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    NOREGWRITE = 3'd0, LB = 3'd1, LH = 3'd2, LW = 3'd3, LBU = 3'd4, LHU = 3'd5
  } reg_write_e;

  typedef enum logic [2:0] {
    NOBRANCH = 3'd0, BEQ = 3'd1, BNE = 3'd2, BLT = 3'd3, BLTU = 3'd4, BGE = 3'd5, BGEU = 3'd6
  } branch_e;

  // Codes 11..14 are the RV32M groups: MUL/MULH, MULHSU/MULHU, DIV/DIVU, REM/REMU.
  typedef enum logic [3:0] {
    ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_SRA = 4'd2, ALU_ADD = 4'd3, ALU_SUB = 4'd4,
    ALU_XOR = 4'd5, ALU_OR = 4'd6, ALU_AND = 4'd7, ALU_SLT = 4'd8, ALU_SLTU = 4'd9,
    ALU_LUI = 4'd10, ALU_MUL = 4'd11, ALU_MULHU = 4'd12, ALU_DIV = 4'd13, ALU_REM = 4'd14
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    RTYPE = 3'd0, ITYPE = 3'd1, STYPE = 3'd2, BTYPE = 3'd3, UTYPE = 3'd4, JTYPE = 3'd5
  } imm_type_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [1:0] SRC2_REG   = 2'b00;
  localparam logic [1:0] SRC2_SHAMT = 2'b01;
  localparam logic [1:0] SRC2_IMM   = 2'b10;

  typedef struct packed {
    logic       jal;
    logic       jalr;
    logic       mem_to_reg;
    logic       load_npc;
    logic       alu_src1;
    reg_write_e reg_write;
    logic [3:0] mem_write;
    logic [1:0] reg_read;
    branch_e    branch_type;
    alu_ctrl_e  alu_ctrl;
    logic [1:0] alu_src2;
    imm_type_e  imm_type;
  } ctrl_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Combinational RV32I instruction -> control bundle; RV32M decode when RV32M_EN is defined.
module rv_decode_comb
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        is_md,
  output logic        is_div
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    is_md   = 1'b0;
    is_div  = 1'b0;
    case (op)
      OP_LUI: begin
        ctrl.reg_write = LW;
        ctrl.alu_ctrl  = ALU_LUI;
        ctrl.alu_src2  = SRC2_IMM;
        ctrl.imm_type  = UTYPE;
      end
      OP_AUIPC: begin
        ctrl.reg_write = LW;
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.alu_src1  = 1'b1;
        ctrl.alu_src2  = SRC2_IMM;
        ctrl.imm_type  = UTYPE;
      end
      OP_JAL: begin
        ctrl.jal       = 1'b1;
        ctrl.load_npc  = 1'b1;
        ctrl.reg_write = LW;
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.imm_type  = JTYPE;
      end
      OP_JALR: begin
        ctrl.jalr      = 1'b1;
        ctrl.load_npc  = 1'b1;
        ctrl.reg_write = LW;
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.alu_src2  = SRC2_IMM;
        ctrl.imm_type  = ITYPE;
        ctrl.reg_read  = 2'b10;
        illegal        = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.imm_type = BTYPE;
        ctrl.reg_read = 2'b11;
        case (f3)
          3'b000:  ctrl.branch_type = BEQ;
          3'b001:  ctrl.branch_type = BNE;
          3'b100:  ctrl.branch_type = BLT;
          3'b101:  ctrl.branch_type = BGE;
          3'b110:  ctrl.branch_type = BLTU;
          3'b111:  ctrl.branch_type = BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_ctrl   = ALU_ADD;
        ctrl.alu_src2   = SRC2_IMM;
        ctrl.imm_type   = ITYPE;
        ctrl.reg_read   = 2'b10;
        case (f3)
          3'b000:  ctrl.reg_write = LB;
          3'b001:  ctrl.reg_write = LH;
          3'b010:  ctrl.reg_write = LW;
          3'b100:  ctrl.reg_write = LBU;
          3'b101:  ctrl.reg_write = LHU;
          default: illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        ctrl.alu_ctrl = ALU_ADD;
        ctrl.alu_src2 = SRC2_IMM;
        ctrl.imm_type = STYPE;
        ctrl.reg_read = 2'b11;
        case (f3)
          3'b000:  ctrl.mem_write = 4'b0001;
          3'b001:  ctrl.mem_write = 4'b0011;
          3'b010:  ctrl.mem_write = 4'b1111;
          default: illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        ctrl.reg_write = LW;
        ctrl.alu_src2  = SRC2_IMM;
        ctrl.imm_type  = ITYPE;
        ctrl.reg_read  = 2'b10;
        case (f3)
          3'b000: ctrl.alu_ctrl = ALU_ADD;
          3'b010: ctrl.alu_ctrl = ALU_SLT;
          3'b011: ctrl.alu_ctrl = ALU_SLTU;
          3'b100: ctrl.alu_ctrl = ALU_XOR;
          3'b110: ctrl.alu_ctrl = ALU_OR;
          3'b111: ctrl.alu_ctrl = ALU_AND;
          3'b001: begin
            ctrl.alu_src2 = SRC2_SHAMT;
            ctrl.alu_ctrl = ALU_SLL;
            illegal       = (f7 != 7'b0000000);
          end
          default: begin
            ctrl.alu_src2 = SRC2_SHAMT;
            if (f7 == 7'b0000000)      ctrl.alu_ctrl = ALU_SRL;
            else if (f7 == 7'b0100000) ctrl.alu_ctrl = ALU_SRA;
            else                       illegal = 1'b1;
          end
        endcase
      end
      OP_REG: begin
        ctrl.reg_write = LW;
        ctrl.alu_src2  = SRC2_REG;
        ctrl.imm_type  = RTYPE;
        ctrl.reg_read  = 2'b11;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000:  ctrl.alu_ctrl = ALU_ADD;
              3'b001:  ctrl.alu_ctrl = ALU_SLL;
              3'b010:  ctrl.alu_ctrl = ALU_SLT;
              3'b011:  ctrl.alu_ctrl = ALU_SLTU;
              3'b100:  ctrl.alu_ctrl = ALU_XOR;
              3'b101:  ctrl.alu_ctrl = ALU_SRL;
              3'b110:  ctrl.alu_ctrl = ALU_OR;
              default: ctrl.alu_ctrl = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (f3 == 3'b000)      ctrl.alu_ctrl = ALU_SUB;
            else if (f3 == 3'b101) ctrl.alu_ctrl = ALU_SRA;
            else                   illegal = 1'b1;
          end
`ifdef RV32M_EN
          7'b0000001: begin
            ctrl.alu_ctrl = alu_ctrl_e'(4'd11 + {2'b00, f3[2:1]});
            is_md         = 1'b1;
            is_div        = f3[2];
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl   = '0;
      is_md  = 1'b0;
      is_div = 1'b0;
    end
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered ID/EX decode stage: handshake, stall/flush, illegal capture.
// RV32M_EN enables multiply/divide decode and the issue hold-off that follows it.
module decode_ctrl_pipe
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT   = 3,
  parameter int unsigned DIV_LAT   = 33,
  parameter int unsigned ILL_CNT_W = 8
) (
  input  logic                 CPU_CLK,
  input  logic                 CPU_RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic                 stall_ex,
  input  logic                 flush,
  output logic                 out_valid,
  output logic                 jal,
  output logic                 jalr,
  output logic                 mem_to_reg,
  output logic                 load_npc,
  output logic                 alu_src1,
  output logic [2:0]           reg_write,
  output logic [3:0]           mem_write,
  output logic [1:0]           reg_read,
  output logic [2:0]           branch_type,
  output logic [3:0]           alu_ctrl,
  output logic [1:0]           alu_src2,
  output logic [2:0]           imm_type,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_cnt,
  output logic [31:0]          ill_first
);

  localparam logic [5:0] MUL_HOLD = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_HOLD = 6'(DIV_LAT - 1);
  localparam logic [ILL_CNT_W-1:0] CNT_ONE = ILL_CNT_W'(1);

  ctrl_t                dec_ctrl, ctrl_d, ctrl_q;
  logic                 dec_illegal, dec_md, dec_div;
  logic                 valid_d, valid_q, illegal_d, illegal_q;
  logic [ILL_CNT_W-1:0] ill_cnt_d, ill_cnt_q;
  logic [31:0]          ill_first_d, ill_first_q;
  logic [5:0]           md_cnt_d, md_cnt_q;
  logic                 busy, accept;

  rv_decode_comb u_dec (
    .instr   (instr),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .is_md   (dec_md),
    .is_div  (dec_div)
  );

  assign busy     = (md_cnt_q != '0);
  assign in_ready = !CPU_RST && !busy && (!valid_q || !stall_ex);
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d     = valid_q;
    ctrl_d      = ctrl_q;
    illegal_d   = illegal_q;
    ill_cnt_d   = ill_cnt_q;
    ill_first_d = ill_first_q;
    md_cnt_d    = busy ? md_cnt_q - 6'd1 : '0;
    if (flush) begin
      valid_d   = 1'b0;
      ctrl_d    = '0;
      illegal_d = 1'b0;
      md_cnt_d  = '0;
    end else if (accept) begin
      valid_d   = 1'b1;
      ctrl_d    = dec_ctrl;
      illegal_d = dec_illegal;
      if (dec_illegal) begin
        if (ill_cnt_q == '0) ill_first_d = instr;
        if (ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + CNT_ONE;
      end
      if (dec_md) md_cnt_d = dec_div ? DIV_HOLD : MUL_HOLD;
    end else if (!stall_ex) begin
      valid_d   = 1'b0;
      ctrl_d    = '0;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
      ill_cnt_q   <= '0;
      ill_first_q <= '0;
      md_cnt_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
      ill_cnt_q   <= ill_cnt_d;
      ill_first_q <= ill_first_d;
      md_cnt_q    <= md_cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign jal         = ctrl_q.jal;
  assign jalr        = ctrl_q.jalr;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign load_npc    = ctrl_q.load_npc;
  assign alu_src1    = ctrl_q.alu_src1;
  assign reg_write   = ctrl_q.reg_write;
  assign mem_write   = ctrl_q.mem_write;
  assign reg_read    = ctrl_q.reg_read;
  assign branch_type = ctrl_q.branch_type;
  assign alu_ctrl    = ctrl_q.alu_ctrl;
  assign alu_src2    = ctrl_q.alu_src2;
  assign imm_type    = ctrl_q.imm_type;
  assign illegal     = illegal_q;
  assign ill_cnt     = ill_cnt_q;
  assign ill_first   = ill_first_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Randomized bench for decode_ctrl_pipe against an instruction-level reference model.
module tb_decode_ctrl_pipe;

  localparam int unsigned MUL_LAT   = 3;
  localparam int unsigned DIV_LAT   = 4;
  localparam int unsigned ILL_CNT_W = 8;
  localparam int unsigned CNT_MAX   = (1 << ILL_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, in_valid, stall_ex, flush, in_ready, out_valid;
  logic [31:0] instr;
  logic jal, jalr, mem_to_reg, load_npc, alu_src1, illegal;
  logic [2:0] reg_write, branch_type, imm_type;
  logic [3:0] mem_write, alu_ctrl;
  logic [1:0] reg_read, alu_src2;
  logic [ILL_CNT_W-1:0] ill_cnt;
  logic [31:0] ill_first;

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .ILL_CNT_W(ILL_CNT_W)) dut (
    .CPU_CLK(clk), .CPU_RST(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .stall_ex(stall_ex), .flush(flush), .out_valid(out_valid), .jal(jal), .jalr(jalr),
    .mem_to_reg(mem_to_reg), .load_npc(load_npc), .alu_src1(alu_src1), .reg_write(reg_write),
    .mem_write(mem_write), .reg_read(reg_read), .branch_type(branch_type), .alu_ctrl(alu_ctrl),
    .alu_src2(alu_src2), .imm_type(imm_type), .illegal(illegal), .ill_cnt(ill_cnt),
    .ill_first(ill_first)
  );

  typedef struct packed {
    logic jal, jalr, m2r, npc, src1;
    logic [2:0] rw;
    logic [3:0] mw;
    logic [1:0] rr;
    logic [2:0] bt;
    logic [3:0] alu;
    logic [1:0] src2;
    logic [2:0] imm;
  } bund_t;

  // funct3-indexed lookup tables taken from the ISA listing
  localparam logic [3:0] ALU_TAB [8] = '{4'd3, 4'd0, 4'd8, 4'd9, 4'd5, 4'd1, 4'd6, 4'd7};
  localparam logic [2:0] BT_TAB  [8] = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd5, 3'd4, 3'd6};
  localparam logic [2:0] RW_TAB  [8] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd5, 3'd0, 3'd0};
  localparam logic [3:0] MW_TAB  [8] = '{4'h1, 4'h3, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

  bit          m_valid, m_ill;
  bund_t       m_b;
  int unsigned m_cnt;
  logic [31:0] m_first;
  int          m_busy;
  int          vectors = 0, miscompares = 0, checks = 0;

  function automatic bit ref_decode(input logic [31:0] w, output bund_t b, output int hold);
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    bit ill = 0;
    b = '0;
    hold = 0;
    case (op)
      7'h37: begin b.rw = 3; b.alu = 10; b.src2 = 2; b.imm = 4; end
      7'h17: begin b.rw = 3; b.alu = 3; b.src1 = 1; b.src2 = 2; b.imm = 4; end
      7'h6F: begin b.jal = 1; b.npc = 1; b.rw = 3; b.alu = 3; b.imm = 5; end
      7'h67: begin
        b.jalr = 1; b.npc = 1; b.rw = 3; b.alu = 3; b.src2 = 2; b.imm = 1; b.rr = 2;
        ill = (f3 != 0);
      end
      7'h63: begin b.bt = BT_TAB[f3]; b.alu = 4; b.imm = 3; b.rr = 3; ill = (b.bt == 0); end
      7'h03: begin
        b.rw = RW_TAB[f3]; b.m2r = 1; b.alu = 3; b.src2 = 2; b.imm = 1; b.rr = 2;
        ill = (b.rw == 0);
      end
      7'h23: begin
        b.mw = MW_TAB[f3]; b.alu = 3; b.src2 = 2; b.imm = 2; b.rr = 3; ill = (b.mw == 0);
      end
      7'h13: begin
        b.rw = 3; b.imm = 1; b.rr = 2; b.alu = ALU_TAB[f3];
        b.src2 = (f3 == 1 || f3 == 5) ? 2'd1 : 2'd2;
        if (f3 == 1) ill = (f7 != 0);
        if (f3 == 5) begin
          if (f7 == 7'h20) b.alu = 2;
          else ill = (f7 != 0);
        end
      end
      7'h33: begin
        b.rw = 3; b.rr = 3;
        if (f7 == 0) b.alu = ALU_TAB[f3];
        else if (f7 == 7'h20) begin
          if (f3 == 0) b.alu = 4;
          else if (f3 == 5) b.alu = 2;
          else ill = 1;
        end
`ifdef RV32M_EN
        else if (f7 == 7'h01) begin
          b.alu = 4'(11 + f3 / 2);
          hold = (f3 >= 4) ? int'(DIV_LAT) - 1 : int'(MUL_LAT) - 1;
        end
`endif
        else ill = 1;
      end
      default: ill = 1;
    endcase
    if (ill) begin b = '0; hold = 0; end
    return ill;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, check in_ready, advance model and DUT, check registered outputs.
  task automatic step(input bit r, input bit v, input logic [31:0] w, input bit s, input bit f);
    bit    exp_ready, acc, ill;
    bund_t b;
    int    hold, nb;
    rst = r; in_valid = v; instr = w; stall_ex = s; flush = f;
    #1;
    exp_ready = !r && (m_busy == 0) && (!m_valid || !s);
    check("in_ready", in_ready, exp_ready);
    @(posedge clk);
    vectors++;
    if (r) begin
      m_valid = 0; m_ill = 0; m_b = '0; m_cnt = 0; m_first = '0; m_busy = 0;
    end else begin
      acc = v && exp_ready;
      nb = (m_busy > 0) ? m_busy - 1 : 0;
      if (f) begin
        m_valid = 0; m_ill = 0; m_b = '0; nb = 0;
      end else if (acc) begin
        ill = ref_decode(w, b, hold);
        m_valid = 1; m_b = b; m_ill = ill;
        if (ill) begin
          if (m_cnt == 0) m_first = w;
          if (m_cnt < CNT_MAX) m_cnt++;
        end
        if (hold > 0) nb = hold;
      end else if (!s) begin
        m_valid = 0; m_ill = 0; m_b = '0;
      end
      m_busy = nb;
    end
    #1;
    check("bundle", {out_valid, illegal, jal, jalr, mem_to_reg, load_npc, alu_src1, reg_write,
                     mem_write, reg_read, branch_type, alu_ctrl, alu_src2, imm_type},
          {m_valid, m_ill, m_b});
    check("ill_cnt", ill_cnt, m_cnt);
    check("ill_first", ill_first, m_first);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 9);
    if (k < 9) w[6:0] = ops[k];
    if (w[6:0] == 7'h13 || w[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  initial begin
    step(1, 0, 32'h0, 0, 0);
    step(1, 0, 32'h0, 0, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_ill_cnt", ill_cnt, 0);

    step(0, 1, 32'h00500093, 0, 0);
    check("addi_valid", out_valid, 1);
    check("addi_alu", alu_ctrl, 3);
    check("addi_src2", alu_src2, 2);
    check("addi_imm", imm_type, 1);
    check("addi_rw", reg_write, 3);
    check("addi_rr", reg_read, 2);

    step(0, 0, 32'h0, 0, 0);
    step(0, 1, 32'h0000A103, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h00500093, 1, 0);
      check("lw_hold_m2r", mem_to_reg, 1);
      check("lw_hold_rw", reg_write, 3);
      check("lw_hold_ready", in_ready, 0);
    end
    step(0, 0, 32'h0, 0, 0);

    step(0, 1, 32'h00208463, 0, 1);
    check("flush_valid", out_valid, 0);
    check("flush_bt", branch_type, 0);

    step(0, 1, 32'hFFFFFFFF, 0, 0);
    check("ill1_flag", illegal, 1);
    check("ill1_rw", reg_write, 0);
    step(0, 1, 32'h0000007F, 0, 0);
    check("ill2_flag", illegal, 1);
    check("ill2_cnt", ill_cnt, 2);
    check("ill2_first", ill_first, 32'hFFFFFFFF);

`ifdef RV32M_EN
    step(0, 1, 32'h0220C1B3, 0, 0);
    check("div_alu", alu_ctrl, 13);
    check("div_busy", in_ready, 0);
    step(0, 0, 32'h0, 0, 0);
    step(0, 0, 32'h0, 0, 1);
    check("div_flush_ready", in_ready, 1);
`else
    step(0, 1, 32'h0220C1B3, 0, 0);
    check("div_illegal", illegal, 1);
`endif

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, rand_instr(),
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);

    step(1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 300; i++) step(0, 1, 32'hFFFFFFFF, 0, 0);
    check("sat_cnt", ill_cnt, CNT_MAX);
    check("sat_first", ill_first, 32'hFFFFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
